// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding memory request, 2-entry instruction
// buffer feeding the IF/ID register, with redirect flush and response discard.
module if_stage #(
  parameter logic [7:0]  RESET_PC  = 8'h00,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        stall,
  input  logic        redirect,
  input  logic [7:0]  redirect_pc,
  output logic [15:0] instr_out,
  output logic [7:0]  pc_out,
  output logic        instr_valid
);

  typedef enum logic [1:0] {StFetch, StWait, StDiscard} state_e;

  state_e           state_q, state_d;
  logic [7:0]       pc_q, pc_d;
  logic [7:0]       iss_q, iss_d;     // address of the outstanding request
  logic [1:0]       count_q, count_d;
  logic [1:0][23:0] fifo_q, fifo_d;   // entry = {pc, instr}, entry 0 is the head

  logic        buf_full;
  logic        issue;
  logic        push;
  logic        pop;
  logic [23:0] push_ent;

  assign buf_full = (count_q >= 2'(BUF_DEPTH));
  // rst gates the request so nothing is issued while reset is held
  assign issue    = rst && (state_q == StFetch) && !buf_full && !redirect;
  assign push     = (state_q == StWait) && imem_valid && !redirect;
  assign pop      = (count_q != 2'd0) && !stall && !redirect;
  assign push_ent = {iss_q, imem_rdata};

  assign imem_req    = issue;
  assign imem_addr   = pc_q;
  assign instr_valid = (count_q != 2'd0);
  assign instr_out   = instr_valid ? fifo_q[0][15:0]  : 16'h0000;
  assign pc_out      = instr_valid ? fifo_q[0][23:16] : 8'h00;

  // Fetch control: PC, issued address and request state
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    iss_d   = iss_q;
    if (redirect) begin
      pc_d = redirect_pc;
      unique case (state_q)
        StFetch:          state_d = StFetch;
        StWait, StDiscard: state_d = imem_valid ? StFetch : StDiscard;
        default:          state_d = StFetch;
      endcase
    end else begin
      unique case (state_q)
        StFetch: begin
          if (issue) begin
            iss_d   = pc_q;
            pc_d    = pc_q + 8'd1;
            state_d = StWait;
          end
        end
        StWait:    if (imem_valid) state_d = StFetch;
        StDiscard: if (imem_valid) state_d = StFetch;
        default:   state_d = StFetch;
      endcase
    end
  end

  // Instruction buffer next state; redirect flushes regardless of push/pop
  always_comb begin
    fifo_d  = fifo_q;
    count_d = count_q;
    if (redirect) begin
      count_d = 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          fifo_d[count_q[0]] = push_ent;
          count_d            = count_q + 2'd1;
        end
        2'b01: begin
          fifo_d[0] = fifo_q[1];
          count_d   = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            fifo_d[0] = push_ent;
          end else begin
            fifo_d[0] = fifo_q[1];
            fifo_d[1] = push_ent;
          end
        end
        default: ;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      iss_q   <= 8'h00;
      count_q <= 2'd0;
      fifo_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      iss_q   <= iss_d;
      count_q <= count_d;
      fifo_q  <= fifo_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: behavioural queue model plus directed sequences.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata = 16'h0000;
  logic        imem_valid = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;
  logic [15:0] instr_out;
  logic [7:0]  pc_out;
  logic        instr_valid;

  if_stage dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .instr_out  (instr_out),
    .pc_out     (pc_out),
    .instr_valid(instr_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: program counter, outstanding flag, discard flag, queue of {pc, instr}
  logic [7:0]  m_pc = 8'h00;
  logic [7:0]  m_iss = 8'h00;
  logic        m_out = 1'b0;
  logic        m_disc = 1'b0;
  logic [23:0] m_q[$];

  // Memory: one pending response, latency mem_lat (0 = random 1..3)
  logic        mem_pend = 1'b0;
  int          mem_cnt = 0;
  logic [7:0]  mem_addr = 8'h00;
  int          mem_lat = 1;

  logic [7:0]  req_log[$];
  logic [7:0]  pop_log[$];

  // DUT outputs sampled in the last step
  logic        s_req, s_valid;
  logic [7:0]  s_addr, s_pc;
  logic [15:0] s_instr;

  typedef struct {
    logic        s;
    logic        r;
    logic [7:0]  rp;
    logic        e_req;
    logic [7:0]  e_addr;
    logic        e_valid;
    logic [7:0]  e_pc;
    logic [15:0] e_instr;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic clear_logs();
    req_log.delete();
    pop_log.delete();
  endtask

  // One clock cycle: drive at negedge, check at negedge+1, advance model, wait posedge.
  task automatic step(input logic s, input logic r, input logic [7:0] rp);
    logic        exp_req;
    logic        vin;
    logic [15:0] din;
    logic        do_pop;
    logic        issue_now;
    @(negedge clk);
    stall       = s;
    redirect    = r;
    redirect_pc = rp;
    if (mem_pend && mem_cnt == 0) begin
      imem_valid = 1'b1;
      imem_rdata = 16'hA000 + {8'h00, mem_addr};
      mem_pend   = 1'b0;
    end else begin
      imem_valid = 1'b0;
      imem_rdata = 16'($urandom);
      if (mem_pend) mem_cnt--;
    end
    #1;
    s_req = imem_req; s_addr = imem_addr; s_valid = instr_valid;
    s_pc = pc_out; s_instr = instr_out;
    exp_req = !m_out && (m_q.size() < 2) && !r;
    chk("instr_valid", instr_valid, m_q.size() > 0);
    if (m_q.size() > 0) begin
      chk("pc_out", pc_out, m_q[0][23:16]);
      chk("instr_out", instr_out, m_q[0][15:0]);
    end else begin
      chk("pc_out bubble", pc_out, 8'h00);
      chk("instr_out bubble", instr_out, 16'h0000);
    end
    chk("imem_req", imem_req, exp_req);
    if (exp_req && imem_req) chk("imem_addr", imem_addr, m_pc);
    if (imem_req) begin
      req_log.push_back(imem_addr);
      mem_pend = 1'b1;
      mem_addr = imem_addr;
      mem_cnt  = (mem_lat == 0) ? int'($urandom_range(2, 0)) : mem_lat - 1;
    end
    if (instr_valid && !s && !r) pop_log.push_back(pc_out);
    vin = imem_valid;
    din = imem_rdata;
    do_pop = (m_q.size() > 0) && !s;
    issue_now = !m_out && (m_q.size() < 2);
    if (r) begin
      m_q.delete();
      m_pc = rp;
      if (m_out) begin
        if (vin) begin m_out = 1'b0; m_disc = 1'b0; end
        else m_disc = 1'b1;
      end
    end else begin
      if (do_pop) void'(m_q.pop_front());
      if (m_out && vin) begin
        if (!m_disc) m_q.push_back({m_iss, din});
        m_out = 1'b0;
        m_disc = 1'b0;
      end else if (issue_now) begin
        m_iss = m_pc;
        m_pc  = m_pc + 8'd1;
        m_out = 1'b1;
      end
    end
    @(posedge clk);
  endtask

  // Reset: mid = assert between edges right after the last step; keep_mem keeps a pending response.
  task automatic do_reset(input bit mid, input bit keep_mem);
    if (mid) #3;
    else @(negedge clk);
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; imem_valid = 1'b0;
    #1;
    chk("reset imem_req", imem_req, 1'b0);
    chk("reset instr_valid", instr_valid, 1'b0);
    chk("reset instr_out", instr_out, 16'h0000);
    chk("reset pc_out", pc_out, 8'h00);
    m_q.delete(); m_pc = 8'h00; m_out = 1'b0; m_disc = 1'b0;
    if (!keep_mem) mem_pend = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
  endtask

  initial begin
    logic seen05;
    vecs[0] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 16'h0000};
    vecs[1] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000};
    vecs[2] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b1, 8'h00, 16'hA000};
    vecs[3] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000};
    vecs[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 1'b1, 8'h01, 16'hA001};
    vecs[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000};

    // Free-running fetch with 1-cycle memory
    mem_lat = 1;
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(vecs[i].s, vecs[i].r, vecs[i].rp);
      chk($sformatf("vec%0d req", i), s_req, vecs[i].e_req);
      if (vecs[i].e_req) chk($sformatf("vec%0d addr", i), s_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d valid", i), s_valid, vecs[i].e_valid);
      chk($sformatf("vec%0d pc", i), s_pc, vecs[i].e_pc);
      chk($sformatf("vec%0d instr", i), s_instr, vecs[i].e_instr);
    end

    // Stall held 10 cycles: buffer fills with 00, 01 then fetch stops
    do_reset(1'b0, 1'b0);
    clear_logs();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'h00);
    chk("stall req count", req_log.size(), 2);
    if (req_log.size() >= 2) begin
      chk("stall req0", req_log[0], 8'h00);
      chk("stall req1", req_log[1], 8'h01);
    end
    chk("stall valid held", s_valid, 1'b1);
    chk("stall pc held", s_pc, 8'h00);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 8'h00);
    chk("stall pop count", pop_log.size() >= 2, 1'b1);
    if (pop_log.size() >= 2) begin
      chk("stall pop0", pop_log[0], 8'h00);
      chk("stall pop1", pop_log[1], 8'h01);
    end
    if (req_log.size() >= 3) chk("stall resume addr", req_log[2], 8'h02);
    else chk("stall resume count", req_log.size(), 3);

    // Redirect to 40 while waiting on 05 with 3-cycle latency
    mem_lat = 3;
    do_reset(1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h05);
    step(1'b1, 1'b0, 8'h00);
    chk("wait05 issued", s_req && (s_addr == 8'h05), 1'b1);
    step(1'b1, 1'b1, 8'h40);
    clear_logs();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'h00);
    if (req_log.size() >= 1) chk("discard next addr", req_log[0], 8'h40);
    else chk("discard req seen", req_log.size(), 1);
    seen05 = 1'b0;
    foreach (pop_log[i]) if (pop_log[i] == 8'h05) seen05 = 1'b1;
    chk("discard no pc05", seen05, 1'b0);

    // Redirect with same-cycle response and pop
    mem_lat = 1;
    do_reset(1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h80);
    chk("rdpop valid before", s_valid, 1'b1);
    step(1'b0, 1'b0, 8'h00);
    chk("rdpop flushed", s_valid, 1'b0);
    chk("rdpop req", s_req, 1'b1);
    chk("rdpop addr", s_addr, 8'h80);

    // PC wrap FE, FF, 00, 01
    do_reset(1'b0, 1'b0);
    step(1'b0, 1'b1, 8'hFE);
    clear_logs();
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 8'h00);
    if (req_log.size() >= 4 && pop_log.size() >= 4) begin
      chk("wrap req0", req_log[0], 8'hFE); chk("wrap req1", req_log[1], 8'hFF);
      chk("wrap req2", req_log[2], 8'h00); chk("wrap req3", req_log[3], 8'h01);
      chk("wrap pop0", pop_log[0], 8'hFE); chk("wrap pop1", pop_log[1], 8'hFF);
      chk("wrap pop2", pop_log[2], 8'h00); chk("wrap pop3", pop_log[3], 8'h01);
    end else chk("wrap log sizes", req_log.size() >= 4 && pop_log.size() >= 4, 1'b1);

    // Reset mid-WAIT with a stray response right after release
    do_reset(1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    mem_lat = 3;
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    chk("midwait valid before", s_valid, 1'b1);
    mem_lat = 1;
    do_reset(1'b1, 1'b1);
    mem_cnt = 0;
    clear_logs();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 8'h00);
    if (req_log.size() >= 1) chk("stray first fetch", req_log[0], 8'h00);
    else chk("stray req seen", req_log.size(), 1);
    if (pop_log.size() >= 1) chk("stray first pop", pop_log[0], 8'h00);
    else chk("stray pop seen", pop_log.size(), 1);

    // Random traffic against the model
    mem_lat = 0;
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(9, 0) < 3, $urandom_range(19, 0) == 0, 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
